// File: rtl/fetch_queue_unit.sv
// Instruction fetch front-end: one ICache request in flight, follows the predictor's
// next PC, buffers {instruction, PC, predicted next PC} in a show-ahead FIFO, and
// discards responses that belong to a fetch stream killed by a redirect.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic [ADDR_W-1:0]          pred_next_pc,
    input  logic                       clr,
    input  logic [ADDR_W-1:0]          clr_pc,
    output logic [ADDR_W-1:0]          icache_addr,
    output logic                       icache_rn,
    input  logic [INST_W-1:0]          icache_data,
    input  logic                       icache_ready,
    output logic                       inst_valid,
    output logic [INST_W-1:0]          inst,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic [ADDR_W-1:0]          inst_pred_pc,
    input  logic                       inst_accept,
    output logic [ADDR_W-1:0]          fetch_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIssue, StWait, StDrop} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rn_q, rn_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         drop_q, drop_d;

    logic [INST_W-1:0]   mem_inst_q [DEPTH];
    logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];
    logic [ADDR_W-1:0]   mem_pred_q [DEPTH];

    logic push, pop, drop, flush;

    assign inst_valid   = (count_q != '0);
    assign inst         = mem_inst_q[rd_ptr_q];
    assign inst_pc      = mem_pc_q[rd_ptr_q];
    assign inst_pred_pc = mem_pred_q[rd_ptr_q];
    assign icache_addr  = addr_q;
    // A frozen pulse is never sampled by the ICache, which shares rdy.
    assign icache_rn    = rn_q & rdy;
    assign fetch_pc     = fetch_pc_q;
    assign count        = count_q;
    assign drop_count   = drop_q;

    // Fetch FSM next state and FIFO control; a redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rn_d       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        flush      = 1'b0;
        if (clr) begin
            flush      = 1'b1;
            fetch_pc_d = clr_pc;
            case (state_q)
                StWait: begin
                    if (icache_ready) begin
                        drop    = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (icache_ready) begin
                        drop    = 1'b1;
                        state_d = StIssue;
                    end
                end
                default: state_d = StIssue;
            endcase
        end else begin
            pop = inst_valid & inst_accept;
            case (state_q)
                StIssue: begin
                    // Issuing only below DEPTH reserves the slot the response will use.
                    if (count_q < DepthCnt) begin
                        rn_d    = 1'b1;
                        addr_d  = fetch_pc_q;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (icache_ready) begin
                        push       = 1'b1;
                        fetch_pc_d = pred_next_pc;
                        state_d    = StIssue;
                    end
                end
                StDrop: begin
                    if (icache_ready) begin
                        drop    = 1'b1;
                        state_d = StIssue;
                    end
                end
                default: state_d = StIssue;
            endcase
        end
    end

    // Pointer, occupancy and discard-counter next values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (drop) begin
            drop_d = drop_q + 32'd1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers, frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIssue;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            rn_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rn_q       <= rn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    // FIFO storage; cleared on reset so the head fields read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
                mem_pred_q[i] <= '0;
            end
        end else if (rdy && push) begin
            mem_inst_q[wr_ptr_q] <= icache_data;
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_pred_q[wr_ptr_q] <= pred_next_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: reset, straight-line fill, pop, redirects, rdy freeze.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pred_next_pc;
    logic        clr;
    logic [31:0] clr_pc;
    logic [31:0] icache_addr;
    logic        icache_rn;
    logic [31:0] icache_data;
    logic        icache_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pred_pc;
    logic        inst_accept;
    logic [31:0] fetch_pc;
    logic [2:0]  count;
    logic [31:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Straight-line predictor.
    assign pred_next_pc = fetch_pc + 32'd4;

    fetch_queue_unit #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .pred_next_pc(pred_next_pc),
        .clr         (clr),
        .clr_pc      (clr_pc),
        .icache_addr (icache_addr),
        .icache_rn   (icache_rn),
        .icache_data (icache_data),
        .icache_ready(icache_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pred_pc(inst_pred_pc),
        .inst_accept (inst_accept),
        .fetch_pc    (fetch_pc),
        .count       (count),
        .drop_count  (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample/drive point is 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a request pulse.
    task automatic wait_rn(input string tag);
        int n = 0;
        while (icache_rn !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {63'd0, icache_rn}, 64'd1);
    endtask

    // ICache with latency 2: response presented on the second edge after the request.
    task automatic serve(input logic [31:0] addr);
        tick();
        icache_ready = 1'b1;
        icache_data  = 32'hA000_0000 | addr;
        tick();
        icache_ready = 1'b0;
        icache_data  = '0;
    endtask

    initial begin
        int rn_seen;
        rst          = 1'b1;
        rdy          = 1'b1;
        clr          = 1'b0;
        clr_pc       = '0;
        icache_data  = '0;
        icache_ready = 1'b0;
        inst_accept  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rn",    {63'd0, icache_rn}, 64'd0);
        check("rst_addr",  {32'd0, icache_addr}, 64'd0);
        check("rst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_drop",  {32'd0, drop_count}, 64'd0);
        check("rst_inst",  {32'd0, inst}, 64'd0);
        rst = 1'b0;

        // First edge after release issues the reset PC
        tick();
        check("first_rn",   {63'd0, icache_rn}, 64'd1);
        check("first_addr", {32'd0, icache_addr}, 64'd0);

        // Straight-line fill of 4 entries
        for (int i = 0; i < 4; i++) begin
            wait_rn("fill_rn");
            check("fill_addr", {32'd0, icache_addr}, 64'(i * 4));
            serve(icache_addr);
        end
        check("full_count", {61'd0, count}, 64'd4);
        check("full_valid", {63'd0, inst_valid}, 64'd1);
        check("full_pc",    {32'd0, inst_pc}, 64'd0);
        check("full_inst",  {32'd0, inst}, 64'hA000_0000);
        check("full_pred",  {32'd0, inst_pred_pc}, 64'd4);
        check("full_fpc",   {32'd0, fetch_pc}, 64'h10);
        rn_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (icache_rn === 1'b1) rn_seen++;
        end
        check("full_no_rn", 64'(rn_seen), 64'd0);

        // Pop one entry; the freed slot triggers the next request
        inst_accept = 1'b1;
        tick();
        inst_accept = 1'b0;
        check("pop_count", {61'd0, count}, 64'd3);
        check("pop_pc",    {32'd0, inst_pc}, 64'd4);
        check("pop_pred",  {32'd0, inst_pred_pc}, 64'd8);
        check("pop_inst",  {32'd0, inst}, 64'hA000_0004);
        check("pop_rn0",   {63'd0, icache_rn}, 64'd0);
        tick();
        check("pop_rn1",   {63'd0, icache_rn}, 64'd1);
        check("pop_addr",  {32'd0, icache_addr}, 64'h10);

        // Redirect while waiting: flush, then discard the late response
        clr    = 1'b1;
        clr_pc = 32'h100;
        tick();
        clr = 1'b0;
        check("clr_count", {61'd0, count}, 64'd0);
        check("clr_valid", {63'd0, inst_valid}, 64'd0);
        check("clr_fpc",   {32'd0, fetch_pc}, 64'h100);
        check("clr_drop0", {32'd0, drop_count}, 64'd0);
        icache_ready = 1'b1;
        icache_data  = 32'hDEAD_0010;
        tick();
        icache_ready = 1'b0;
        check("late_count", {61'd0, count}, 64'd0);
        check("late_drop",  {32'd0, drop_count}, 64'd1);
        check("late_valid", {63'd0, inst_valid}, 64'd0);
        wait_rn("clr_rn");
        check("clr_addr", {32'd0, icache_addr}, 64'h100);

        // Redirect coinciding with the response
        tick();
        clr          = 1'b1;
        clr_pc       = 32'h200;
        icache_ready = 1'b1;
        icache_data  = 32'hDEAD_0100;
        tick();
        clr          = 1'b0;
        icache_ready = 1'b0;
        check("clr2_count", {61'd0, count}, 64'd0);
        check("clr2_drop",  {32'd0, drop_count}, 64'd2);
        check("clr2_fpc",   {32'd0, fetch_pc}, 64'h200);
        wait_rn("clr2_rn");
        check("clr2_addr", {32'd0, icache_addr}, 64'h200);
        serve(32'h200);
        check("push200_count", {61'd0, count}, 64'd1);
        check("push200_inst",  {32'd0, inst}, 64'hA000_0200);
        wait_rn("next_rn");
        check("next_addr", {32'd0, icache_addr}, 64'h204);

        // rdy low for 3 cycles while waiting, consumer trying to accept
        tick();
        rdy         = 1'b0;
        inst_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_count", {61'd0, count}, 64'd1);
            check("frz_pc",    {32'd0, inst_pc}, 64'h200);
            check("frz_fpc",   {32'd0, fetch_pc}, 64'h204);
            check("frz_addr",  {32'd0, icache_addr}, 64'h204);
            check("frz_rn",    {63'd0, icache_rn}, 64'd0);
        end
        rdy          = 1'b1;
        inst_accept  = 1'b0;
        icache_ready = 1'b1;
        icache_data  = 32'hA000_0204;
        tick();
        icache_ready = 1'b0;
        check("resume_count", {61'd0, count}, 64'd2);
        check("resume_pc",    {32'd0, inst_pc}, 64'h200);
        check("resume_fpc",   {32'd0, fetch_pc}, 64'h208);
        wait_rn("resume_rn");
        check("resume_addr", {32'd0, icache_addr}, 64'h208);

        // Asynchronous reset mid-WAIT
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", {61'd0, count}, 64'd0);
        check("arst_valid", {63'd0, inst_valid}, 64'd0);
        check("arst_drop",  {32'd0, drop_count}, 64'd0);
        check("arst_addr",  {32'd0, icache_addr}, 64'd0);
        check("arst_fpc",   {32'd0, fetch_pc}, 64'd0);
        check("arst_pc",    {32'd0, inst_pc}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rel_rn",   {63'd0, icache_rn}, 64'd1);
        check("rel_addr", {32'd0, icache_addr}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
